// File: rtl/mult_hazard_unit_pkg.sv
// Shared constants and types for the multiplier hazard/stall controller.
package mult_hazard_unit_pkg;

  // MUL is R-type (OP) with the M-extension funct7.
  localparam logic [6:0] OpMul     = 7'b0110011;
  localparam logic [6:0] Funct7Mul = 7'b0000001;

  localparam int unsigned MulLatencyDefault = 3;
  // Wide enough for the largest legal latency (15).
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OpMul) && (funct7 == Funct7Mul);
  endfunction

endpackage

// File: rtl/mult_hazard_unit_counter.sv
// Down-counter that times a multiply: loaded on issue, decremented while busy,
// flags the final busy cycle.
module mul_latency_counter
  import mult_hazard_unit_pkg::*;
#(
  parameter int unsigned Width = CntW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  // Load takes priority over decrement (issue from DONE reloads).
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/mult_hazard_unit.sv
// Hazard/stall controller for a pipeline with a multi-cycle multiplier.
// Issues MUL from ID, tracks it until its dedicated-port writeback, and stalls
// dependent/conflicting ID instructions plus classic load-use hazards.
module mult_hazard_unit
  import mult_hazard_unit_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = MulLatencyDefault,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [6:0]            id_funct7,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  flush,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_bubble,
  output logic                  mul_start,
  output logic                  mul_busy,
  output logic [REG_ADDR_W-1:0] mul_rd,
  output logic                  mul_wb_valid
);

  mul_state_e            state_d, state_q;
  logic [REG_ADDR_W-1:0] mul_rd_d, mul_rd_q;
  logic                  wb_valid_d, wb_valid_q;
  logic                  cnt_last;

  logic is_mul, load_use, mul_dep, struct_haz, stall;

  // Hazard detection and issue decision for the instruction in ID.
  always_comb begin
    is_mul   = id_valid & is_mul_op(id_opcode, id_funct7);
    load_use = ex_mem_read & (ex_rd != '0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    // No regfile bypass: consumers and WAW writers wait through DONE.
    mul_dep  = (state_q != StIdle) & (mul_rd_q != '0) &
               ((id_use_rs1 & (id_rs1 == mul_rd_q)) |
                (id_use_rs2 & (id_rs2 == mul_rd_q)) |
                (id_reg_write & (id_rd == mul_rd_q)));
    // Single multiplier; it is free again in DONE.
    struct_haz = is_mul & (state_q == StBusy);
    // A squashed instruction never stalls.
    stall      = id_valid & ~flush & (load_use | mul_dep | struct_haz);
    mul_start  = is_mul & ~stall & ~flush;
  end

  // Next-state logic of the multiply tracker.
  always_comb begin
    state_d  = state_q;
    mul_rd_d = mul_rd_q;
    if (mul_start) begin
      mul_rd_d = id_rd;
    end
    unique case (state_q)
      StIdle:  if (mul_start) state_d = StBusy;
      StBusy:  if (cnt_last) state_d = StDone;
      StDone:  state_d = mul_start ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
    wb_valid_d = (state_d == StDone);
  end

  // State registers, synchronous active-low reset drops any in-flight multiply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mul_rd_q   <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mul_rd_q   <= mul_rd_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  mul_latency_counter #(
    .Width(CntW)
  ) u_cnt (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (mul_start),
    .load_val_i(CntW'(MUL_LATENCY - 1)),
    .dec_i     (state_q == StBusy),
    .last_o    (cnt_last)
  );

  // Pipeline control outputs.
  always_comb begin
    pc_write     = ~stall;
    if_id_write  = ~stall;
    id_ex_bubble = stall | mul_start | flush;
    mul_busy     = (state_q != StIdle);
    mul_rd       = mul_rd_q;
    mul_wb_valid = wb_valid_q;
  end

endmodule
